// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop counter bank: mode encoding and width limit.
package tff_pkg;

    localparam int unsigned TFF_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        TFF_HOLD   = 2'b00,
        TFF_COUNT  = 2'b01,
        TFF_TOGGLE = 2'b10,
        TFF_LOAD   = 2'b11
    } tff_mode_e;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop cell: q toggles when t is high; async active-low reset to RESET_BIT.
module tff_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_BIT;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/tff_counter.sv
// Bank of WIDTH T flip-flops driven by a shared toggle-vector generator (hold/count/toggle/load).
// Define TFF_COUNTER_SAT_EN to make COUNT saturate at the limits instead of wrapping.
module tff_counter
    import tff_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] t_in,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic [WIDTH-1:0] chg
);

    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] t_vec;
    logic             tc_next;
    logic             at_max;
    logic             at_min;
    tff_mode_e        mode_e;

    assign mode_e = tff_mode_e'(mode);
    assign at_max = &q;
    assign at_min = ~|q;

    // Ripple toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        t_vec   = '0;
        tc_next = 1'b0;
        if (clear) begin
            t_vec = q ^ RESET_VAL;
        end else begin
            case (mode_e)
                TFF_HOLD: begin
                    t_vec = '0;
                end
                TFF_COUNT: begin
                    if (dir) begin
                        t_vec   = up_t;
                        tc_next = at_max;
`ifdef TFF_COUNTER_SAT_EN
                        if (at_max) t_vec = '0;
`endif
                    end else begin
                        t_vec   = dn_t;
                        tc_next = at_min;
`ifdef TFF_COUNTER_SAT_EN
                        if (at_min) t_vec = '0;
`endif
                    end
                end
                TFF_TOGGLE: begin
                    t_vec = t_in;
                end
                TFF_LOAD: begin
                    t_vec = q ^ load_val;
                end
                default: begin
                    t_vec = '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
        tff_cell #(
            .RESET_BIT(RESET_VAL[g])
        ) u_cell (
            .clk    (clk),
            .reset_n(reset_n),
            .t      (t_vec[g]),
            .q      (q[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tc  <= 1'b0;
            chg <= '0;
        end else begin
            tc  <= tc_next;
            chg <= t_vec;
        end
    end

endmodule
